// File: rtl/move_sched.sv
// Game-input sequencer: MENU/ARM/PLAY mode FSM, one arbitrated cursor move per
// video frame with auto-repeat, cursor clamped to the playfield.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   left/right/up/down    direction key levels
//   enter, game_reset     key levels
//   cursor_x, cursor_y    registered cursor position (y = 0 is top row)
//   move_tick             pulse: cursor changed
//   blocked_tick          pulse: move attempted against the playfield edge
//   sel_tick              pulse: enter pressed while in PLAY
//   state                 00 MENU, 01 ARM, 10 PLAY
module move_sched #(
  parameter int unsigned GRID_W       = 10,
  parameter int unsigned GRID_H       = 20,
  parameter int unsigned XW           = 4,
  parameter int unsigned YW           = 5,
  parameter int unsigned REPEAT_DELAY = 12,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          left,
  input  logic          right,
  input  logic          up,
  input  logic          down,
  input  logic          enter,
  input  logic          game_reset,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          move_tick,
  output logic          blocked_tick,
  output logic          sel_tick,
  output logic [1:0]    state
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_MENU = 2'b00,
    S_ARM  = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    D_NONE  = 3'd0,
    D_LEFT  = 3'd1,
    D_RIGHT = 3'd2,
    D_UP    = 3'd3,
    D_DOWN  = 3'd4
  } dir_t;

  state_t        state_q;
  dir_t          active_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          enter_q;
  logic          move_q, blocked_q, sel_q;

  dir_t          req_c;
  logic          in_range_c;
  logic          enter_rise_c;
  logic          attempt_c;

  // Fixed-priority arbitration and the clamped target cell for the winner.
  always_comb begin
    req_c      = D_NONE;
    x_d        = x_q;
    y_d        = y_q;
    in_range_c = 1'b0;
    if (left)       req_c = D_LEFT;
    else if (right) req_c = D_RIGHT;
    else if (up)    req_c = D_UP;
    else if (down)  req_c = D_DOWN;
    case (req_c)
      D_LEFT: if (x_q != XW'(0)) begin
        in_range_c = 1'b1;
        x_d        = x_q - XW'(1);
      end
      D_RIGHT: if (x_q != XW'(GRID_W - 1)) begin
        in_range_c = 1'b1;
        x_d        = x_q + XW'(1);
      end
      D_UP: if (y_q != YW'(0)) begin
        in_range_c = 1'b1;
        y_d        = y_q - YW'(1);
      end
      D_DOWN: if (y_q != YW'(GRID_H - 1)) begin
        in_range_c = 1'b1;
        y_d        = y_q + YW'(1);
      end
      default: ;
    endcase
  end

  assign enter_rise_c = enter & ~enter_q;
  // A move is attempted on a new winner or when the repeat counter expires.
  assign attempt_c    = (req_c != D_NONE) &&
                        ((req_c != active_q) || (cnt_q == CW'(1)));

  // Mode FSM, repeat state, cursor and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_MENU;
      active_q  <= D_NONE;
      cnt_q     <= '0;
      x_q       <= XW'(GRID_W / 2);
      y_q       <= YW'(GRID_H / 2);
      enter_q   <= 1'b0;
      move_q    <= 1'b0;
      blocked_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      enter_q   <= enter;
      move_q    <= 1'b0;
      blocked_q <= 1'b0;
      sel_q     <= 1'b0;
      if (game_reset) begin
        state_q  <= S_MENU;
        active_q <= D_NONE;
        cnt_q    <= '0;
        x_q      <= XW'(GRID_W / 2);
        y_q      <= YW'(GRID_H / 2);
      end else begin
        case (state_q)
          S_MENU: if (enter_rise_c) state_q <= S_ARM;
          // Wait for the start press to be released so it is not a select.
          S_ARM:  if (!enter) state_q <= S_PLAY;
          S_PLAY: begin
            if (enter_rise_c) sel_q <= 1'b1;
            if (frame_tick) begin
              if (attempt_c) begin
                if (in_range_c) begin
                  x_q    <= x_d;
                  y_q    <= y_d;
                  move_q <= 1'b1;
                end else begin
                  blocked_q <= 1'b1;
                end
              end
              if (req_c == D_NONE) begin
                active_q <= D_NONE;
                cnt_q    <= '0;
              end else if (req_c != active_q) begin
                active_q <= req_c;
                cnt_q    <= CW'(REPEAT_DELAY);
              end else if (cnt_q == CW'(1)) begin
                cnt_q <= CW'(REPEAT_RATE);
              end else if (cnt_q > CW'(1)) begin
                cnt_q <= cnt_q - CW'(1);
              end
            end
          end
          default: state_q <= S_MENU;
        endcase
      end
    end
  end

  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign move_tick    = move_q;
  assign blocked_tick = blocked_q;
  assign sel_tick     = sel_q;
  assign state        = state_q;

endmodule
